// File: rtl/true_dual_port_ram_single_clk.sv
// True dual-port RAM, single clock, two independent read/write ports.
// Write-first on the same port, old data across ports, port B wins a same-address double write.

module true_dual_port_ram_single_clk_port #(
    parameter int DATA_WIDTH   = 8,
    parameter int REGISTER_OUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] q
);
    logic [DATA_WIDTH-1:0] rd;

    // Own write data bypasses the array so this port sees its new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd <= '0;
        else     rd <= we ? wdata : rdata;
    end

    generate
        if (REGISTER_OUT != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] oreg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) oreg <= '0;
                else     oreg <= rd;
            end
            assign q = oreg;
        end else begin : g_noreg
            assign q = rd;
        end
    endgenerate
endmodule

module true_dual_port_ram_single_clk #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int REGISTER_OUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] q_b
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][DATA_WIDTH-1:0] data;
    logic [1:0]                 we;
    logic [1:0][DATA_WIDTH-1:0] q;

    assign addr = {addr_b, addr_a};
    assign data = {data_b, data_a};
    assign we   = {we_b, we_a};

    // Single write process keeps B-over-A ordering deterministic; array is never reset.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
    end

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            true_dual_port_ram_single_clk_port #(
                .DATA_WIDTH  (DATA_WIDTH),
                .REGISTER_OUT(REGISTER_OUT)
            ) u_port (
                .clk  (clk),
                .rst  (rst),
                .we   (we[p]),
                .wdata(data[p]),
                .rdata(mem[addr[p]]),
                .q    (q[p])
            );
        end
    endgenerate

    assign q_a = q[0];
    assign q_b = q[1];
endmodule

// File: tb/tb_true_dual_port_ram_single_clk.sv
// Directed bench: one RAM without and one with the output register, driven in lockstep.

module tb_true_dual_port_ram_single_clk;
    logic       clk;
    logic       rst;
    logic [5:0] addr_a, addr_b;
    logic [7:0] data_a, data_b;
    logic       we_a, we_b;
    logic [7:0] q_a0, q_b0, q_a1, q_b1;

    int errors = 0;
    int checks = 0;

    true_dual_port_ram_single_clk #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .REGISTER_OUT(0)) dut0 (
        .clk(clk), .rst(rst),
        .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a0),
        .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b0)
    );

    true_dual_port_ram_single_clk #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .REGISTER_OUT(1)) dut1 (
        .clk(clk), .rst(rst),
        .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a1),
        .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 1'b0; we_b = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 1);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            addr_a = 6'($urandom); addr_b = 6'($urandom);
            data_a = 8'($urandom); data_b = 8'($urandom);
            we_a = 1'($urandom_range(0, 1)); we_b = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ({q_a0, q_b0, q_a1, q_b1} !== 32'h0) begin
                errors++;
                $display("FAIL reset_q[%0d]: got %h %h %h %h want 0", c, q_a0, q_b0, q_a1, q_b1);
            end
        end
        idle();
        rst = 1'b0;
        we_a = 1'b1; addr_a = 6'd3; data_a = 8'h5A;
        tick();
        idle();
        tick();
        checks++;
        if (q_a0 !== 8'h5A) begin
            errors++;
            $display("FAIL reset_readback: got %h want 5a", q_a0);
        end
    endtask

    task automatic test_latency();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            we_a = 1'b1; addr_a = 6'(i); data_a = 8'(i * 3);
            tick();
        end
        idle();
        addr_a = 6'd0;
        for (int i = 0; i < 8; i++) begin
            addr_b = 6'(i);
            tick();
            exp = 8'(i * 3);
            checks++;
            if (q_b0 !== exp) begin
                errors++;
                $display("FAIL lat0_q_b[%0d]: got %h want %h", i, q_b0, exp);
            end
            if (i > 0) begin
                exp = 8'((i - 1) * 3);
                checks++;
                if (q_b1 !== exp) begin
                    errors++;
                    $display("FAIL lat1_q_b[%0d]: got %h want %h", i, q_b1, exp);
                end
            end
        end
        tick();
        checks++;
        if (q_b1 !== 8'd21) begin
            errors++;
            $display("FAIL lat1_q_b_last: got %h want 15", q_b1);
        end
        // q must hold between edges even if the address changes
        addr_b = 6'd0;
        #1;
        checks++;
        if (q_b0 !== 8'd21) begin
            errors++;
            $display("FAIL lat0_no_comb: got %h want 15", q_b0);
        end
        tick();
        checks++;
        if (q_b0 !== 8'd0) begin
            errors++;
            $display("FAIL lat0_addr0: got %h want 00", q_b0);
        end
    endtask

    task automatic test_swap();
        we_a = 1'b1; addr_a = 6'd4; data_a = 8'h10;
        we_b = 1'b1; addr_b = 6'd5; data_b = 8'h20;
        tick();
        data_a = 8'h20; data_b = 8'h10;
        tick();
        idle();
        addr_a = 6'd5; addr_b = 6'd4;
        tick();
        checks++;
        if (q_a0 !== 8'h10 || q_b0 !== 8'h20) begin
            errors++;
            $display("FAIL swap_read: got mem5=%h mem4=%h want 10 20", q_a0, q_b0);
        end
        addr_a = 6'd4; addr_b = 6'd5;
        tick();
        checks++;
        if (q_a0 !== 8'h20 || q_b0 !== 8'h10) begin
            errors++;
            $display("FAIL swap_read2: got mem4=%h mem5=%h want 20 10", q_a0, q_b0);
        end
    endtask

    task automatic test_collision();
        we_a = 1'b1; addr_a = 6'd9; data_a = 8'h11;
        tick();
        data_a = 8'hAA; addr_b = 6'd9;
        tick();
        checks++;
        if (q_a0 !== 8'hAA) begin
            errors++;
            $display("FAIL coll_write_first: got %h want aa", q_a0);
        end
        checks++;
        if (q_b0 !== 8'h11) begin
            errors++;
            $display("FAIL coll_old_data: got %h want 11", q_b0);
        end
        idle();
        tick();
        checks++;
        if (q_b0 !== 8'hAA) begin
            errors++;
            $display("FAIL coll_next_read: got %h want aa", q_b0);
        end
        checks++;
        if (q_b1 !== 8'h11) begin
            errors++;
            $display("FAIL coll_reg_old: got %h want 11", q_b1);
        end
    endtask

    task automatic test_dual_write();
        we_a = 1'b1; addr_a = 6'd12; data_a = 8'h01;
        we_b = 1'b1; addr_b = 6'd12; data_b = 8'h02;
        tick();
        checks++;
        if (q_a0 !== 8'h01 || q_b0 !== 8'h02) begin
            errors++;
            $display("FAIL dual_own_data: got %h %h want 01 02", q_a0, q_b0);
        end
        idle();
        tick();
        checks++;
        if (q_a0 !== 8'h02 || q_b0 !== 8'h02) begin
            errors++;
            $display("FAIL dual_b_wins: got %h %h want 02 02", q_a0, q_b0);
        end
    endtask

    task automatic test_persistence();
        for (int i = 0; i < 32; i++) begin
            we_a = 1'b1; addr_a = 6'(2 * i);     data_a = pat(2 * i);
            we_b = 1'b1; addr_b = 6'(2 * i + 1); data_b = pat(2 * i + 1);
            if (i == 16) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({q_a0, q_b0, q_a1, q_b1} !== 32'h0) begin
                    errors++;
                    $display("FAIL pers_async_clear: got %h %h %h %h want 0", q_a0, q_b0, q_a1, q_b1);
                end
            end
            tick();
            if (i == 16) begin
                idle();
                for (int c = 0; c < 3; c++) begin
                    checks++;
                    if ({q_a0, q_b0, q_a1, q_b1} !== 32'h0) begin
                        errors++;
                        $display("FAIL pers_rst_q[%0d]: got %h %h %h %h want 0", c, q_a0, q_b0, q_a1, q_b1);
                    end
                    if (c < 2) tick();
                end
                rst = 1'b0;
            end else if (i == 17) begin
                checks++;
                if (q_a0 !== pat(34) || q_b0 !== pat(35)) begin
                    errors++;
                    $display("FAIL pers_resume: got %h %h want %h %h", q_a0, q_b0, pat(34), pat(35));
                end
            end
        end
        idle();
        for (int i = 0; i < 64; i++) begin
            addr_a = 6'(i); addr_b = 6'(63 - i);
            tick();
            checks++;
            if (q_a0 !== pat(i) || q_b0 !== pat(63 - i)) begin
                errors++;
                $display("FAIL pers_read[%0d]: got %h %h want %h %h", i, q_a0, q_b0, pat(i), pat(63 - i));
            end
        end
        addr_b = 6'd63;
        tick();
        tick();
        checks++;
        if (q_b1 !== pat(63)) begin
            errors++;
            $display("FAIL pers_top_reg: got %h want %h", q_b1, pat(63));
        end
    endtask

    initial begin
        rst = 1'b1;
        addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
        we_a = 1'b0; we_b = 1'b0;
        test_reset();
        test_latency();
        test_swap();
        test_collision();
        test_dual_write();
        test_persistence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
